// File: rtl/ncsp_ramp_gen.sv
// Ramp generator that feeds the MASH top level its frequency word.
// It produces a 32-bit word {int[7:0], frac[23:0]} that is static, a sawtooth
// chirp or a triangle chirp. The step size and the step period are
// programmable. The word is presented as four bytes.
//
// Pulse semantics: o_update and o_done are single-cycle, registered pulses
// with no back-pressure. o_update is high exactly in the cycle after acc
// changed value. o_done is high in the cycle the sweep settles into HOLD.
// i_start is honoured only in IDLE/HOLD. i_stop wins over everything.
module ncsp_ramp_gen #(
  parameter int W_DWELL = 16
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic               i_stop,
  input  logic [1:0]         i_mode,
  input  logic               i_cont,
  input  logic [31:0]        i_start_word,
  input  logic [31:0]        i_stop_word,
  input  logic [23:0]        i_step,
  input  logic [W_DWELL-1:0] i_dwell,
  output logic [7:0]         o_int,
  output logic [7:0]         o_msb,
  output logic [7:0]         o_isb,
  output logic [7:0]         o_lsb,
  output logic               o_update,
  output logic               o_busy,
  output logic               o_dir,
  output logic               o_done,
  output logic [1:0]         o_dbg_state
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RUN_UP = 2'd1;
  localparam logic [1:0] S_RUN_DN = 2'd2;
  localparam logic [1:0] S_HOLD   = 2'd3;

  localparam logic [1:0]         MODE_SAW = 2'd1;
  localparam logic [1:0]         MODE_TRI = 2'd2;
  localparam logic [W_DWELL-1:0] CNT_ONE  = {{(W_DWELL-1){1'b0}}, 1'b1};

  logic [1:0]         state, state_nxt;
  logic [31:0]        acc, acc_nxt;
  logic [W_DWELL-1:0] cnt, cnt_nxt;
  logic               done_nxt;
  logic               load_cfg;

  // Configuration captured when a start is accepted
  logic [1:0]         mode_r;
  logic               cont_r;
  logic [31:0]        start_r;
  logic [31:0]        stop_r;
  logic [23:0]        step_r;
  logic [W_DWELL-1:0] dwell_r;

  // 33-bit arithmetic so neither direction can wrap around silently
  logic [32:0] up_sum;
  logic [32:0] dn_diff;
  logic        start_ramps;

  assign up_sum  = {1'b0, acc} + {9'b0, step_r};
  assign dn_diff = {1'b0, acc} - {9'b0, step_r};

  // A ramp only runs for a real chirp mode with a non-zero step and room to climb.
  assign start_ramps = ((i_mode == MODE_SAW) || (i_mode == MODE_TRI)) &&
                       (i_step != 24'd0) && (i_start_word < i_stop_word);

  assign o_int       = acc[31:24];
  assign o_msb       = acc[23:16];
  assign o_isb       = acc[15:8];
  assign o_lsb       = acc[7:0];
  assign o_dbg_state = state;

  // Next-state, next-word and dwell-counter decisions
  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    done_nxt  = 1'b0;
    load_cfg  = 1'b0;
    if (i_stop) begin
      state_nxt = S_IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        S_IDLE, S_HOLD: begin
          if (i_start) begin
            load_cfg = 1'b1;
            acc_nxt  = i_start_word;
            cnt_nxt  = i_dwell;
            if (start_ramps) begin
              state_nxt = S_RUN_UP;
            end else begin
              state_nxt = S_HOLD;
              done_nxt  = 1'b1;
            end
          end
        end
        S_RUN_UP: begin
          if (cnt != '0) begin
            cnt_nxt = cnt - CNT_ONE;
          end else begin
            cnt_nxt = dwell_r;
            // Sitting on stop in RUN_UP only happens on a continuous sawtooth
            // that has already saturated: this step is the wrap back to start.
            if (acc == stop_r) begin
              acc_nxt = start_r;
            end else if (up_sum < {1'b0, stop_r}) begin
              acc_nxt = up_sum[31:0];
            end else begin
              acc_nxt = stop_r;
              if (mode_r == MODE_TRI) begin
                state_nxt = S_RUN_DN;
              end else if (!cont_r) begin
                state_nxt = S_HOLD;
                done_nxt  = 1'b1;
              end
            end
          end
        end
        S_RUN_DN: begin
          if (cnt != '0) begin
            cnt_nxt = cnt - CNT_ONE;
          end else begin
            cnt_nxt = dwell_r;
            if (!dn_diff[32] && (dn_diff[31:0] > start_r)) begin
              acc_nxt = dn_diff[31:0];
            end else begin
              acc_nxt = start_r;
              if (cont_r) begin
                state_nxt = S_RUN_UP;
              end else begin
                state_nxt = S_HOLD;
                done_nxt  = 1'b1;
              end
            end
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // State, word, counter and registered status outputs
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= S_IDLE;
      acc      <= 32'd0;
      cnt      <= '0;
      o_update <= 1'b0;
      o_done   <= 1'b0;
      o_busy   <= 1'b0;
      o_dir    <= 1'b0;
    end else begin
      state    <= state_nxt;
      acc      <= acc_nxt;
      cnt      <= cnt_nxt;
      o_update <= (acc_nxt != acc);
      o_done   <= done_nxt;
      o_busy   <= (state_nxt == S_RUN_UP) || (state_nxt == S_RUN_DN);
      o_dir    <= (state_nxt == S_RUN_DN);
    end
  end

  // Configuration capture on an accepted start
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      mode_r  <= 2'd0;
      cont_r  <= 1'b0;
      start_r <= 32'd0;
      stop_r  <= 32'd0;
      step_r  <= 24'd0;
      dwell_r <= '0;
    end else if (load_cfg) begin
      mode_r  <= i_mode;
      cont_r  <= i_cont;
      start_r <= i_start_word;
      stop_r  <= i_stop_word;
      step_r  <= i_step;
      dwell_r <= i_dwell;
    end
  end

endmodule

// File: tb/tb_ncsp_ramp_gen.sv
// Bench for ncsp_ramp_gen: directed chirp scenarios plus randomized configs,
// checked cycle by cycle against a reference model of the ramp rules.
module tb_ncsp_ramp_gen;

  localparam int W_DWELL = 16;

  localparam int M_IDLE = 0;
  localparam int M_UP   = 1;
  localparam int M_DN   = 2;
  localparam int M_HOLD = 3;

  logic               i_clk = 1'b0;
  logic               i_rst;
  logic               i_start;
  logic               i_stop;
  logic [1:0]         i_mode;
  logic               i_cont;
  logic [31:0]        i_start_word;
  logic [31:0]        i_stop_word;
  logic [23:0]        i_step;
  logic [W_DWELL-1:0] i_dwell;
  logic [7:0]         o_int, o_msb, o_isb, o_lsb;
  logic               o_update, o_busy, o_dir, o_done;
  logic [1:0]         o_dbg_state;
  logic [31:0]        word;

  ncsp_ramp_gen #(.W_DWELL(W_DWELL)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_stop(i_stop),
    .i_mode(i_mode), .i_cont(i_cont), .i_start_word(i_start_word),
    .i_stop_word(i_stop_word), .i_step(i_step), .i_dwell(i_dwell),
    .o_int(o_int), .o_msb(o_msb), .o_isb(o_isb), .o_lsb(o_lsb),
    .o_update(o_update), .o_busy(o_busy), .o_dir(o_dir), .o_done(o_done),
    .o_dbg_state(o_dbg_state)
  );

  assign word = {o_int, o_msb, o_isb, o_lsb};

  // clock / reset block
  always #5 i_clk = ~i_clk;

  int n_tests = 0;
  int n_fail  = 0;

  // scoreboard: expected sequence of words seen on o_update
  logic [31:0] exp_q[$];
  bit          sb_on = 1'b0;

  // reference model
  int     m_st;
  longint m_acc, m_start, m_stop, m_step, m_period, m_next, cyc;
  int     m_mode;
  bit     m_cont, m_wrap, m_upd, m_done;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = M_IDLE; m_acc = 0; m_wrap = 0; m_upd = 0; m_done = 0;
    m_mode = 0; m_cont = 0; m_start = 0; m_stop = 0; m_step = 0; m_period = 1; m_next = 0;
  endtask

  // One clock edge of the ramp rules, applied to the inputs present at the edge.
  task automatic model_step();
    longint old_acc;
    longint nxt;
    old_acc = m_acc;
    cyc++;
    m_done = 0;
    if (i_stop) begin
      m_st = M_IDLE;
    end else if ((m_st == M_IDLE || m_st == M_HOLD) && i_start) begin
      m_mode   = int'(i_mode);
      m_cont   = i_cont;
      m_start  = longint'(i_start_word);
      m_stop   = longint'(i_stop_word);
      m_step   = longint'(i_step);
      m_period = longint'(i_dwell) + 1;
      m_acc    = m_start;
      m_wrap   = 0;
      m_next   = cyc + m_period;
      if ((m_mode == 1 || m_mode == 2) && m_step != 0 && m_start < m_stop) m_st = M_UP;
      else begin m_st = M_HOLD; m_done = 1; end
    end else if ((m_st == M_UP || m_st == M_DN) && cyc == m_next) begin
      m_next = cyc + m_period;
      if (m_st == M_UP) begin
        if (m_wrap) begin
          m_acc = m_start; m_wrap = 0;
        end else begin
          nxt = m_acc + m_step;
          if (nxt < m_stop) m_acc = nxt;
          else begin
            m_acc = m_stop;
            if (m_mode == 2) m_st = M_DN;
            else if (m_cont) m_wrap = 1;
            else begin m_st = M_HOLD; m_done = 1; end
          end
        end
      end else begin
        if (m_acc - m_step > m_start) m_acc = m_acc - m_step;
        else begin
          m_acc = m_start;
          if (m_cont) m_st = M_UP;
          else begin m_st = M_HOLD; m_done = 1; end
        end
      end
    end
    m_upd = (m_acc != old_acc);
  endtask

  // driver: one clock with given start/stop pulses, then compare against the model
  task automatic tick(input logic s, input logic p);
    logic [31:0] exp_w;
    @(negedge i_clk);
    i_start = s;
    i_stop  = p;
    model_step();
    @(posedge i_clk);
    #1;
    exp_w = m_acc[31:0];
    check_eq("word",   word, exp_w);
    check_eq("update", {31'b0, o_update}, {31'b0, m_upd});
    check_eq("busy",   {31'b0, o_busy}, {31'b0, (m_st == M_UP || m_st == M_DN)});
    check_eq("dir",    {31'b0, o_dir},  {31'b0, (m_st == M_DN)});
    check_eq("done",   {31'b0, o_done}, {31'b0, m_done});
    if (sb_on && o_update) begin
      if (exp_q.size() == 0) check_eq("sb_extra_update", {31'b0, o_update}, 32'd0);
      else check_eq("sb_word", word, exp_q.pop_front());
    end
  endtask

  task automatic set_cfg(input logic [1:0] md, input logic ct, input logic [31:0] sw,
                         input logic [31:0] pw, input logic [23:0] st, input int dw);
    i_mode = md; i_cont = ct; i_start_word = sw; i_stop_word = pw; i_step = st;
    i_dwell = W_DWELL'(dw);
  endtask

  task automatic rand_cfg();
    logic [31:0] sw;
    if ($urandom_range(0, 3) == 0) begin
      sw = 32'hFFFF_F000 + 32'($urandom_range(0, 32'hFFF));
      i_stop_word = 32'hFFFF_FFF0;
    end else begin
      sw = $urandom;
      i_stop_word = sw + 32'($urandom_range(0, 32'h900));
    end
    i_start_word = sw;
    i_step  = ($urandom_range(0, 5) == 0) ? 24'd0 : 24'($urandom_range(1, 32'h300));
    i_dwell = W_DWELL'($urandom_range(0, 3));
    i_mode  = 2'($urandom_range(0, 3));
    i_cont  = 1'($urandom_range(0, 1));
  endtask

  task automatic sb_finish(input string tag);
    check_eq(tag, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    sb_on = 1'b0;
  endtask

  initial begin
    i_rst = 1'b1; i_start = 1'b0; i_stop = 1'b0;
    set_cfg(2'd0, 1'b0, 32'd0, 32'd0, 24'd0, 0);
    cyc = 0;
    model_reset();
    #3;
    check_eq("rst_word",  word, 32'd0);
    check_eq("rst_flags", {28'b0, o_update, o_busy, o_dir, o_done}, 32'd0);
    check_eq("rst_state", {30'b0, o_dbg_state}, 32'd0);
    repeat (2) @(posedge i_clk);
    #1 i_rst = 1'b0;

    // static word
    set_cfg(2'd0, 1'b0, 32'h1E80_0000, 32'h0, 24'h0, 0);
    tick(1, 0);
    check_eq("static_int", {24'b0, o_int}, 32'h1E);
    check_eq("static_msb", {24'b0, o_msb}, 32'h80);
    check_eq("static_isb_lsb", {16'b0, o_isb, o_lsb}, 32'h0);
    check_eq("static_flags", {28'b0, o_update, o_done, o_busy, o_dir}, 32'b1100);
    repeat (3) tick(0, 0);

    // single sawtooth
    set_cfg(2'd1, 1'b0, 32'h1000_0000, 32'h1000_0300, 24'h100, 2);
    exp_q = '{32'h1000_0000, 32'h1000_0100, 32'h1000_0200, 32'h1000_0300};
    sb_on = 1'b1;
    tick(1, 0);
    repeat (14) tick(0, 0);
    sb_finish("saw_single_left");
    check_eq("saw_single_hold_busy", {31'b0, o_busy}, 32'd0);

    // continuous sawtooth: stop held a full period then wrap
    set_cfg(2'd1, 1'b1, 32'h1000_0000, 32'h1000_0300, 24'h100, 2);
    exp_q = '{32'h1000_0000, 32'h1000_0100, 32'h1000_0200, 32'h1000_0300,
              32'h1000_0000, 32'h1000_0100, 32'h1000_0200, 32'h1000_0300};
    sb_on = 1'b1;
    tick(1, 0);
    repeat (21) tick(0, 0);
    sb_finish("saw_cont_left");
    check_eq("saw_cont_busy", {31'b0, o_busy}, 32'd1);
    tick(0, 1);

    // single triangle
    set_cfg(2'd2, 1'b0, 32'h1000_0000, 32'h1000_0250, 24'h100, 0);
    exp_q = '{32'h1000_0000, 32'h1000_0100, 32'h1000_0200, 32'h1000_0250,
              32'h1000_0150, 32'h1000_0050, 32'h1000_0000};
    sb_on = 1'b1;
    tick(1, 0);
    repeat (8) tick(0, 0);
    sb_finish("tri_left");

    // start and stop together: stop wins
    set_cfg(2'd1, 1'b0, 32'h2000_0000, 32'h2000_0300, 24'h100, 0);
    tick(1, 1);
    check_eq("startstop_word", word, 32'h1000_0000);
    check_eq("startstop_busy", {31'b0, o_busy}, 32'd0);

    // abort mid-ramp at 0x200
    set_cfg(2'd1, 1'b0, 32'h1000_0000, 32'h1000_0300, 24'h100, 0);
    tick(1, 0);
    tick(0, 0);
    tick(0, 0);
    tick(0, 1);
    check_eq("abort_word", word, 32'h1000_0200);
    check_eq("abort_busy", {31'b0, o_busy}, 32'd0);
    repeat (3) tick(0, 0);

    // degenerate configs
    set_cfg(2'd1, 1'b0, 32'h3000_0000, 32'h3000_0300, 24'h0, 1);
    tick(1, 0);
    check_eq("deg_step0_done", {31'b0, o_done}, 32'd1);
    tick(0, 0);
    set_cfg(2'd2, 1'b1, 32'h4000_0000, 32'h4000_0000, 24'h10, 1);
    tick(1, 0);
    check_eq("deg_eq_done", {31'b0, o_done}, 32'd1);
    tick(0, 0);

    // asynchronous reset mid-ramp
    set_cfg(2'd1, 1'b1, 32'h1000_0000, 32'h1000_0300, 24'h100, 0);
    tick(1, 0);
    repeat (2) tick(0, 0);
    #1 i_rst = 1'b1;
    #1;
    check_eq("arst_word",  word, 32'd0);
    check_eq("arst_flags", {28'b0, o_update, o_busy, o_dir, o_done}, 32'd0);
    #1 i_rst = 1'b0;
    model_reset();
    repeat (2) tick(0, 0);

    // randomized configs, including mid-run config churn and random pulses
    for (int r = 0; r < 40; r++) begin
      rand_cfg();
      tick(1, 0);
      for (int c = 0; c < int'($urandom_range(20, 90)); c++) begin
        rand_cfg();
        tick($urandom_range(0, 7) == 0, $urandom_range(0, 49) == 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
